multi_flux_fifo: RTL and testbench

Tagged multi-flux FIFO that sits at the other end of the actor FIFO protocol. It accepts tagged tokens from a producer actor's write port and demultiplexes them by tag into per-flux circular queues. It exposes them to a consumer actor's read port as per-flux empty/read handshakes over a shared first-word-fall-through data bus. It is the channel placed between HEVC dataflow actors, such as the multiplier feeding a downstream adder, when several data fluxes share one physical actor.

---
 rtl/multi_flux_fifo_pkg.sv | 23 ++
 rtl/multi_flux_fifo_queue.sv | 71 +++++++
 rtl/multi_flux_fifo.sv | 105 ++++++++++
 tb/tb_multi_flux_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_flux_fifo_pkg.sv
// Shared defaults and width helpers for the tagged multi-flux FIFO.
package mfifo_pkg;

    localparam int MFIFO_FLUX       = 2;
    localparam int MFIFO_DATA_WIDTH = 18;
    localparam int MFIFO_DEPTH      = 8;

    // A single flux still carries one tag bit so the token layout stays uniform.
    function automatic int mfifo_tag_w(input int flux);
        int w;
        w = $clog2(flux);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int mfifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int mfifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/multi_flux_fifo_queue.sv
// mfifo_queue: single-flux circular buffer with registered pointers and count.
module mfifo_queue
    import mfifo_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8,
    localparam int PW   = mfifo_ptr_w(DEPTH),
    localparam int CW   = mfifo_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign push_ok = push_i && !full_o;
    // A pop on an empty queue is ignored, so a same-cycle push still lands.
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/multi_flux_fifo.sv
// Tagged multi-flux FIFO: demuxes tokens by tag into per-flux queues, FWFT shared dout.
// Optional sticky per-flux error flags (err_o) are built when MFIFO_ERR_EN is defined.
module multi_flux_fifo
    import mfifo_pkg::*;
#(
    parameter int FLUX       = MFIFO_FLUX,
    parameter int DATA_WIDTH = MFIFO_DATA_WIDTH,
    parameter int DEPTH      = MFIFO_DEPTH,
    localparam int TAG_WIDTH = mfifo_tag_w(FLUX),
    localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH,
    localparam int CW        = mfifo_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             write_i,
    output logic             full_o,
    output logic [WIDTH-1:0] dout_o,
    output logic [FLUX-1:0]  empty_o,
    input  logic [FLUX-1:0]  read_i
`ifdef MFIFO_ERR_EN
    ,
    output logic [FLUX-1:0]  err_o
`endif
);

    logic [TAG_WIDTH-1:0] tag;
    logic                 tag_ok;
    logic [FLUX-1:0]      q_push;
    logic [FLUX-1:0]      q_full;
    logic [WIDTH-1:0]     q_head  [FLUX];
    logic [CW-1:0]        q_count [FLUX];

    assign tag    = din_i[WIDTH-1 -: TAG_WIDTH];
    assign tag_ok = int'(tag) < FLUX;
    // Full is conservative: the writer picks its tag after sampling it.
    assign full_o = |q_full;

    for (genvar i = 0; i < FLUX; i++) begin : g_q
        assign q_push[i] = write_i && !full_o && tag_ok && (tag == TAG_WIDTH'(i));

        mfifo_queue #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_queue (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (q_push[i]),
            .pop_i   (read_i[i]),
            .din_i   (din_i),
            .head_o  (q_head[i]),
            .count_o (q_count[i]),
            .empty_o (empty_o[i]),
            .full_o  (q_full[i])
        );
    end

    always_comb begin
        logic found;
        dout_o = '0;
        found  = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            if (!found && read_i[i] && !empty_o[i]) begin
                dout_o = q_head[i];
                found  = 1'b1;
            end
        end
        for (int i = 0; i < FLUX; i++) begin
            if (!found && !empty_o[i]) begin
                dout_o = q_head[i];
                found  = 1'b1;
            end
        end
    end

`ifdef MFIFO_ERR_EN
    logic [FLUX-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q | (read_i & empty_o);
        if (write_i) begin
            if (!tag_ok) begin
                err_d[0] = 1'b1;
            end else if (full_o) begin
                for (int i = 0; i < FLUX; i++) begin
                    if (tag == TAG_WIDTH'(i)) begin
                        err_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_multi_flux_fifo.sv
// Randomized plus directed bench for multi_flux_fifo against a queue-based reference model.
module tb_multi_flux_fifo;
    import mfifo_pkg::*;

    localparam int FLUX  = MFIFO_FLUX;
    localparam int DW    = MFIFO_DATA_WIDTH;
    localparam int DEPTH = MFIFO_DEPTH;
    localparam int TW    = mfifo_tag_w(FLUX);
    localparam int WIDTH = DW + TW;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             write;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic [FLUX-1:0]  empty;
    logic [FLUX-1:0]  read;
`ifdef MFIFO_ERR_EN
    logic [FLUX-1:0]  err;
    logic [FLUX-1:0]  m_err;
    logic [FLUX-1:0]  obs_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mq [FLUX][$];
    logic [WIDTH-1:0] obs_dout;
    logic [FLUX-1:0]  obs_empty;
    logic             obs_full;

    always #5 clk = ~clk;

    multi_flux_fifo dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .din_i   (din),
        .write_i (write),
        .full_o  (full),
        .dout_o  (dout),
        .empty_o (empty),
        .read_i  (read)
`ifdef MFIFO_ERR_EN
        ,
        .err_o   (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] tok(input int t, input int d);
        logic [WIDTH-1:0] v;
        v = (WIDTH'(t) << DW) | WIDTH'(d & ((1 << DW) - 1));
        return v;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < FLUX; i++) if (mq[i].size() >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [FLUX-1:0] m_empty();
        logic [FLUX-1:0] e;
        for (int i = 0; i < FLUX; i++) e[i] = (mq[i].size() == 0);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] m_dout(input logic [FLUX-1:0] r);
        for (int i = 0; i < FLUX; i++) if (r[i] && mq[i].size() > 0) return mq[i][0];
        for (int i = 0; i < FLUX; i++) if (mq[i].size() > 0) return mq[i][0];
        return '0;
    endfunction

    task automatic model_edge(input logic w, input logic [WIDTH-1:0] d,
                              input logic [FLUX-1:0] r, input logic rs);
        logic            was_full;
        logic [FLUX-1:0] was_empty;
        int              t;
        was_full  = m_full();
        was_empty = m_empty();
        t         = int'(d[WIDTH-1 -: TW]);
        if (rs) begin
            for (int i = 0; i < FLUX; i++) mq[i].delete();
`ifdef MFIFO_ERR_EN
            m_err = '0;
`endif
        end else begin
`ifdef MFIFO_ERR_EN
            m_err = m_err | (r & was_empty);
            if (w && t >= FLUX) m_err[0] = 1'b1;
            else if (w && was_full) m_err[t] = 1'b1;
`endif
            for (int i = 0; i < FLUX; i++) if (r[i] && !was_empty[i]) void'(mq[i].pop_front());
            if (w && !was_full && t < FLUX) mq[t].push_back(d);
        end
    endtask

    task automatic drive(input logic w, input logic [WIDTH-1:0] d,
                         input logic [FLUX-1:0] r, input logic rs);
        @(negedge clk);
        write = w;
        din   = d;
        read  = r;
        rst   = rs;
        #1;
        obs_dout  = dout;
        obs_empty = empty;
        obs_full  = full;
        if (!rs) begin
            check("dout", 32'(dout), 32'(m_dout(r)));
            check("empty", 32'(empty), 32'(m_empty()));
            check("full", 32'(full), 32'(m_full()));
`ifdef MFIFO_ERR_EN
            obs_err = err;
            check("err", 32'(err), 32'(m_err));
`endif
        end
        @(posedge clk);
        model_edge(w, d, r, rs);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        write = 1'b0;
        din   = '0;
        read  = '0;
`ifdef MFIFO_ERR_EN
        m_err = '0;
`endif

        drive(1'b0, '0, '0, 1'b1);
        idle();
        check("rst_empty", 32'(obs_empty), 32'h3);
        check("rst_full", 32'(obs_full), 32'h0);
        check("rst_dout", 32'(obs_dout), 32'h0);

        drive(1'b1, tok(1, 5), '0, 1'b0);
        drive(1'b0, '0, 2'b10, 1'b0);
        check("t1_empty", 32'(obs_empty), 32'h1);
        check("t1_dout", 32'(obs_dout), 32'h40005);
        idle();
        check("t1_pop_empty", 32'(obs_empty), 32'h3);
        check("t1_pop_dout", 32'(obs_dout), 32'h0);

        for (int k = 1; k <= 9; k++) drive(1'b1, tok(0, k), '0, 1'b0);
        idle();
        check("fill_full", 32'(obs_full), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, '0, 2'b01, 1'b0);
            check("fill_pop", 32'(obs_dout), 32'(k));
        end
        idle();
        check("fill_drained", 32'(obs_empty), 32'h3);
        check("fill_unfull", 32'(obs_full), 32'h0);

        drive(1'b1, tok(0, 'hA), '0, 1'b0);
        drive(1'b1, tok(1, 'hB), '0, 1'b0);
        idle();
        check("alt_r00", 32'(obs_dout), 32'h0000A);
        drive(1'b0, '0, 2'b10, 1'b0);
        check("alt_r10", 32'(obs_dout), 32'h4000B);
        drive(1'b0, '0, 2'b01, 1'b0);

        for (int k = 0; k < 3; k++) drive(1'b1, tok(0, 'h10 + k), '0, 1'b0);
        drive(1'b1, tok(0, 'h20), 2'b01, 1'b0);
        check("pp_head", 32'(obs_dout), 32'h10);
        check("pp_count", mq[0].size(), 3);
        for (int k = 0; k < 20; k++) begin
            drive(1'($urandom_range(1, 0)), tok(0, 'h30 + k), 2'($urandom_range(1, 0)), 1'b0);
        end
        drive(1'b0, '0, '0, 1'b1);

        for (int k = 0; k < 5; k++) drive(1'b1, tok(1, 'h50 + k), '0, 1'b0);
        drive(1'b1, tok(1, 'h77), '0, 1'b1);
        idle();
        check("rstw_empty", 32'(obs_empty), 32'h3);
        check("rstw_full", 32'(obs_full), 32'h0);
        check("rstw_dout", 32'(obs_dout), 32'h0);

`ifdef MFIFO_ERR_EN
        drive(1'b0, '0, 2'b01, 1'b0);
        idle();
        check("err_rd_empty", 32'(obs_err), 32'h1);
        for (int k = 0; k < 9; k++) drive(1'b1, tok(1, k), '0, 1'b0);
        idle();
        check("err_wr_full", 32'(obs_err), 32'h3);
        drive(1'b0, '0, '0, 1'b1);
        idle();
        check("err_rst", 32'(obs_err), 32'h0);
`endif

        for (int k = 0; k < 600; k++) begin
            logic             w;
            logic [FLUX-1:0]  r;
            logic             rs;
            int               sel;
            w   = ($urandom_range(99, 0) < 65);
            sel = $urandom_range(9, 0);
            if (sel < 4)      r = '0;
            else if (sel < 9) r = FLUX'(1) << $urandom_range(FLUX - 1, 0);
            else              r = FLUX'($urandom);
            rs  = ($urandom_range(99, 0) == 0);
            drive(w, tok($urandom_range(FLUX - 1, 0), $urandom), r, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
